// File: rtl/fabric_slice_pkg.sv
// Shared types and sizing helpers for the parametrised fabric slice.
// The FABRIC_CARRY_EN macro adds one carry_mode bit to every output field.
package fabric_slice_pkg;

   typedef enum logic [1:0] {
      UNCONFIG = 2'd0,
      LOADING  = 2'd1,
      ACTIVE   = 2'd2
   } fabric_state_t;

   // Control-bit offsets above the 2^K-bit truth table of each field
   localparam int OUT_SEL_OFS = 0;
   localparam int D_SEL_OFS   = 1;
   localparam int CARRY_OFS   = 2;

   function automatic int cfg_field_w(input int k);
`ifdef FABRIC_CARRY_EN
      return (1 << k) + 3;
`else
      return (1 << k) + 2;
`endif
   endfunction

   function automatic int cfg_w(input int k, input int n);
      return n * cfg_field_w(k);
   endfunction

endpackage

// File: rtl/fabric_slice_lut.sv
// 2^K:1 truth-table multiplexer: the LUT of one output pair.
module fabric_slice_lut #(
   parameter int LUT_K = 4
) (
   input  logic [(1 << LUT_K)-1:0] truth,
   input  logic [LUT_K-1:0]        sel,
   output logic                    lut_out
);

   assign lut_out = truth[sel];

endmodule

// File: rtl/fabric_slice_param.sv
// Parametrised LUT/FF fabric slice with in-block configuration chain and load FSM.
// Optional carry chain (fabric_cin/fabric_cout, carry_mode bit) enabled by FABRIC_CARRY_EN.
module fabric_slice_param
   import fabric_slice_pkg::*;
#(
   parameter int LUT_K   = 4,
   parameter int NUM_OUT = 2
) (
   input  logic               fabric_clk,
   input  logic               fabric_reset,
   input  logic               prog_en,
   input  logic               ccff_head,
   input  logic               test_enable,
   input  logic [LUT_K-1:0]   fabric_in,
   input  logic               fabric_reg_in,
   input  logic               fabric_sc_in,
`ifdef FABRIC_CARRY_EN
   input  logic               fabric_cin,
   output logic               fabric_cout,
`endif
   output logic [NUM_OUT-1:0] fabric_out,
   output logic               fabric_reg_out,
   output logic               fabric_sc_out,
   output logic               ccff_tail,
   output logic               config_done
);

   localparam int TT_W  = 1 << LUT_K;
   localparam int F     = cfg_field_w(LUT_K);
   localparam int CFG_W = cfg_w(LUT_K, NUM_OUT);
   localparam logic [15:0] CNT_LAST = 16'(CFG_W - 1);

   logic [CFG_W-1:0]   cfg_reg;
   logic [NUM_OUT-1:0] q_reg, q_next;
   logic [NUM_OUT-1:0] lut_raw, lut_eff;
   logic [NUM_OUT-1:0] out_sel, d_sel;
   logic [NUM_OUT-1:0] chain_in, scan_in;
   fabric_state_t      state_reg, state_next;
   logic [15:0]        cnt_reg, cnt_next;
   logic               active;

   assign active = (state_reg == ACTIVE);

`ifdef FABRIC_CARRY_EN
   logic [NUM_OUT:0] carry;
   assign carry[0] = fabric_cin;
`endif

   generate
      for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
         logic [F-1:0] field;
         assign field = cfg_reg[gi*F +: F];

         fabric_slice_lut #(.LUT_K(LUT_K)) u_lut (
            .truth   (field[TT_W-1:0]),
            .sel     (fabric_in),
            .lut_out (lut_raw[gi])
         );

         assign out_sel[gi] = field[TT_W + OUT_SEL_OFS];
         assign d_sel[gi]   = field[TT_W + D_SEL_OFS];

         if (gi == 0) begin : g_head
            assign chain_in[gi] = fabric_reg_in;
            assign scan_in[gi]  = fabric_sc_in;
         end else begin : g_link
            assign chain_in[gi] = q_reg[gi-1];
            assign scan_in[gi]  = q_reg[gi-1];
         end

`ifdef FABRIC_CARRY_EN
         // LUT output acts as propagate; otherwise generate from the shared input
         assign carry[gi+1] = lut_raw[gi] ? carry[gi] : fabric_in[gi % LUT_K];
         assign lut_eff[gi] = lut_raw[gi] ^ (field[TT_W + CARRY_OFS] & carry[gi]);
`else
         assign lut_eff[gi] = lut_raw[gi];
`endif

         assign fabric_out[gi] = active & (out_sel[gi] ? q_reg[gi] : lut_eff[gi]);
      end
   endgenerate

   always_ff @(posedge fabric_clk) begin
      if (fabric_reset) begin
         cfg_reg <= '0;
      end else if (prog_en) begin
         cfg_reg <= {cfg_reg[CFG_W-2:0], ccff_head};
      end
   end

   // Configuration shifting freezes the user flops; scan beats functional capture
   always_comb begin
      q_next = q_reg;
      if (!prog_en) begin
         if (test_enable) begin
            q_next = scan_in;
         end else if (active) begin
            q_next = (d_sel & chain_in) | (~d_sel & lut_eff);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         UNCONFIG: begin
            if (prog_en) begin
               state_next = LOADING;
               cnt_next   = 16'd1;
            end
         end
         LOADING: begin
            if (prog_en) begin
               if (cnt_reg == CNT_LAST) begin
                  state_next = ACTIVE;
                  cnt_next   = 16'd0;
               end else begin
                  cnt_next = cnt_reg + 16'd1;
               end
            end
         end
         ACTIVE: begin
            if (prog_en) begin
               state_next = LOADING;
               cnt_next   = 16'd1;
            end
         end
         default: begin
            state_next = UNCONFIG;
            cnt_next   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge fabric_clk) begin
      if (fabric_reset) begin
         q_reg     <= '0;
         state_reg <= UNCONFIG;
         cnt_reg   <= 16'd0;
      end else begin
         q_reg     <= q_next;
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign fabric_reg_out = active & q_reg[NUM_OUT-1];
   assign fabric_sc_out  = q_reg[NUM_OUT-1];
   assign ccff_tail      = cfg_reg[CFG_W-1];
   assign config_done    = active;
`ifdef FABRIC_CARRY_EN
   assign fabric_cout    = active & carry[NUM_OUT];
`endif

endmodule

// File: doc/fabric_slice_param.md
# fabric_slice_param

Parametrised successor to the fixed two-output fle physical fabric. It generalises the number of LUT/FF output pairs and the LUT input count, and brings the configuration chain in-block with a load-tracking FSM. Outputs are gated until a complete bitstream has been shifted in. It sits inside the CLB fle and is driven by the CLB routing muxes and the tile configuration chain.

## Interface
- LUT_K, 4, LUT inputs per output (2..6)
- NUM_OUT, 2, output pairs (LUT + FF), 1..8
- Derived: F = 2^LUT_K + 2 config bits per output; CFG_W = NUM_OUT*F
- fabric_clk in 1: single clock for user logic and configuration
- fabric_reset in 1: synchronous, active-high, clears everything
- prog_en in 1: shift configuration chain this cycle
- ccff_head in 1: configuration serial in
- test_enable in 1: scan mode
- fabric_in in LUT_K: shared LUT inputs
- fabric_reg_in in 1: register-chain input to FF0
- fabric_sc_in in 1: scan input to FF0
- fabric_out out NUM_OUT: per-output result
- fabric_reg_out out 1: Q of FF[NUM_OUT-1]
- fabric_sc_out out 1: Q of FF[NUM_OUT-1], ungated
- ccff_tail out 1: cfg[CFG_W-1]
- config_done out 1: high in ACTIVE

## Operation
- Config chain cfg[CFG_W-1:0]. When prog_en=1: cfg <= {cfg[CFG_W-2:0], ccff_head}. Otherwise it holds.
- Field for output i is cfg[i*F +: F]:
  - bits [2^K-1:0]: truth table.
  - bit 2^K: out_sel (1 = registered).
  - bit 2^K+1: d_sel (1 = chain input).
- lut_i = truth_i[fabric_in].
- FF D selection, in priority order:
  - prog_en: hold.
  - test_enable: FF[i-1] Q, with FF0 taking fabric_sc_in.
  - ACTIVE: d_sel ? (FF[i-1] Q, or fabric_reg_in for i=0) : lut_i.
  - Otherwise: hold.
- fabric_out[i] = ACTIVE ? (out_sel ? Q_i : lut_i) : 0.
- fabric_reg_out is gated the same way.
- fabric_sc_out and ccff_tail are never gated.
- FSM states:
  - UNCONFIG → LOADING on prog_en.
  - LOADING: 16-bit-capable counter cnt increments per prog_en cycle. When prog_en arrives with cnt = CFG_W-1, go to ACTIVE and clear cnt. prog_en low holds cnt and stays LOADING.
  - ACTIVE → LOADING on prog_en (cnt restarts at 1). Outputs gate to 0 that cycle's next edge.
- Reset: cfg, all Q, and cnt go to 0; state goes to UNCONFIG. All outputs are 0.
- Reset while LOADING discards the partial load.

## Timing
- LUT path to fabric_out is combinational, 0 cycles.
- Registered path: 1 cycle.
- config_done rises on the edge that captures the CFG_W-th bit. It is usable from the next cycle.
- ccff_tail carries the bit shifted in CFG_W cycles earlier.
- prog_en and test_enable together: prog_en wins and FFs hold.
- fabric_reset has priority over all other inputs.

## Configuration
- FABRIC_CARRY_EN defined:
  - F gains bit 2^K+2, carry_mode.
  - Ports fabric_cin (in, 1) and fabric_cout (out, 1) are added.
  - Carry chain: c_0 = fabric_cin; c_{i+1} = lut_i ? c_i : fabric_in[i % LUT_K].
  - When carry_mode=1 the effective lut_i becomes lut_i ^ c_i.
  - fabric_cout = c_NUM_OUT, gated to 0 unless ACTIVE.
- FABRIC_CARRY_EN undefined: no carry ports, F = 2^K+2, no carry logic.

## Structure
- Package fabric_slice_pkg holds:
  - state enum {UNCONFIG, LOADING, ACTIVE};
  - functions cfg_field_w(K) and cfg_w(K, N);
  - bit-offset localparams OUT_SEL_OFS, D_SEL_OFS, CARRY_OFS.
- One sub-module, fabric_slice_lut: 2^K:1 truth-table mux, instantiated NUM_OUT times.

## Test plan
- Defaults (CFG_W=36). Reset, then shift 36 bits with output0 truth 0x8000 (AND4), all other fields 0 → config_done high the cycle after the 36th shift. fabric_in=4'hF gives fabric_out[0]=1; 4'hE gives 0.
- Load 20 bits, drop prog_en for 5 cycles, then load the remaining 16 → config_done high after bit 36 only. fabric_out stays 0 throughout loading.
- Output1 out_sel=1, d_sel=1, output0 truth=0xFFFF → Q1 follows Q0 one cycle later; fabric_reg_out = 1 two cycles after ACTIVE.
- test_enable=1 with sc_in sequence 1,0 → fabric_sc_out shows 1 then 0 at cycles 2 and 3.
- While ACTIVE, assert prog_en for one cycle → config_done=0 and fabric_out=0 the next cycle. Then fabric_reset during LOADING → state UNCONFIG, cfg all zero, ccff_tail=0.
- FABRIC_CARRY_EN, both outputs carry_mode with truth=XOR(in0,in1): in=4'b0011, cin=1 → fabric_out=2'b11, cout=1.
